// File: rtl/alu_add_arbiter.sv
// -----------------------------------------------------------------------------
// alu_add_arbiter
//
// Round-robin arbiter that shares a single alu_add datapath between NUM_REQ
// requesters. Each operation takes at least three cycles:
//   1. accept: one requester is granted and its operands are latched,
//   2. execute: the ALU is enabled and its result is registered,
//   3. respond: the result is held until the consumer takes it.
// The round-robin pointer advances only when a response is handed off.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   ID_W       width of the requester index
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request
//   req_ready  one-hot grant, only ever high in IDLE
//   req_a/b    packed 32-bit operands, requester i at [32i+31:32i]
//   req_op     packed 4-bit opcodes, requester i at [4i+3:4i]
//   alu_a/b    latched operands to the ALU
//   alu_opcode latched opcode to the ALU
//   alu_en     ALU enable, high in EXEC only
//   alu_result combinational ALU result
//   resp_valid response available (RESP state)
//   resp_ready consumer accepts the response
//   resp_id    index of the requester that owns the response
//   resp_data  registered ALU result
//   resp_err   latched opcode was outside 0..3
//   busy       high whenever the block is not idle
// -----------------------------------------------------------------------------
module alu_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_opcode,
    output logic                  alu_en,
    input  logic [31:0]           alu_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]      state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [3:0]      op_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     data_q;
    logic            err_q;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [3:0]      sel_op;
    logic [ID_W-1:0] next_ptr;

    // Scan from rr_ptr upward, wrapping, and keep the first valid requester.
    always_comb begin
        int cand;
        logic [ID_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_a  = req_a[32*k +: 32];
                sel_b  = req_b[32*k +: 32];
                sel_op = req_op[4*k +: 4];
            end
        end
    end

    always_comb begin
        if (id_q == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = id_q + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        op_q    <= sel_op;
                        id_q    <= grant_idx;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    data_q  <= alu_result;
                    err_q   <= (op_q > 4'd3);
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        rr_ptr_q <= next_ptr;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Control outputs are gated by rst so they read 0 while reset is held,
    // even though the state register already sits in IDLE.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = !rst && (state_q == ST_IDLE) && grant_found
                           && (grant_idx == ID_W'(k));
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign alu_en     = !rst && (state_q == ST_EXEC);
    assign resp_valid = !rst && (state_q == ST_RESP);
    assign busy       = !rst && (state_q != ST_IDLE);
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_add_arbiter.sv
module tb_alu_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*4-1:0]  req_op;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [3:0]            alu_opcode;
    logic                  alu_en;
    logic [31:0]           alu_result;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_data;
    logic                  resp_err;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    alu_add_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opcode(alu_opcode),
        .alu_en    (alu_en),
        .alu_result(alu_result),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the external alu_add instance.
    always_comb alu_result = ref_alu(alu_a, alu_b, alu_opcode);

    // Round-robin winner: first set bit at or above ptr, wrapping.
    function automatic int pick(logic [NUM_REQ-1:0] v, int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
    endtask

    task automatic scramble_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, $urandom, $urandom,
                    ($urandom_range(0, 7) == 0) ? 4'(($urandom_range(4, 15))) :
                                                  4'($urandom_range(0, 3)));
        end
    endtask

    // One full accept/execute/respond transaction starting from IDLE with
    // the caller's inputs already applied. Stalls resp_ready for 'stall' cycles.
    task automatic transact(input int stall, output int got_id, output logic [31:0] got_data,
                            output logic got_err);
        int          id;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  eo;
        logic [31:0] ed;
        got_id   = -1;
        got_data = '0;
        got_err  = 1'b0;
        #1;
        id = pick(req_valid, m_ptr);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_resp_valid", 64'(resp_valid), 64'd0);
        check("idle_alu_en", 64'(alu_en), 64'd0);
        if (id < 0) begin
            check("idle_ready_none", 64'(req_ready), 64'd0);
            step();
            return;
        end
        check("grant", 64'(req_ready), 64'd1 << id);
        ea = req_a[32*id +: 32];
        eb = req_b[32*id +: 32];
        eo = req_op[4*id +: 4];
        ed = ref_alu(ea, eb, eo);
        step();
        // Inputs change after acceptance; the block must use its latched copy.
        req_valid = NUM_REQ'($urandom);
        scramble_ops();
        #1;
        check("exec_alu_en", 64'(alu_en), 64'd1);
        check("exec_busy", 64'(busy), 64'd1);
        check("exec_ready", 64'(req_ready), 64'd0);
        check("exec_resp_valid", 64'(resp_valid), 64'd0);
        check("exec_alu_a", 64'(alu_a), 64'(ea));
        check("exec_alu_b", 64'(alu_b), 64'(eb));
        check("exec_alu_op", 64'(alu_opcode), 64'(eo));
        step();
        for (int s = 0; s <= stall; s++) begin
            resp_ready = (s == stall);
            req_valid  = NUM_REQ'($urandom);
            #1;
            check("resp_valid", 64'(resp_valid), 64'd1);
            check("resp_id", 64'(resp_id), 64'(id));
            check("resp_data", 64'(resp_data), 64'(ed));
            check("resp_err", 64'(resp_err), 64'(eo > 4'd3));
            check("resp_ready_out", 64'(req_ready), 64'd0);
            check("resp_alu_en", 64'(alu_en), 64'd0);
            got_id   = int'(resp_id);
            got_data = resp_data;
            got_err  = resp_err;
            step();
        end
        resp_ready = 1'b0;
        m_ptr = (id + 1) % NUM_REQ;
    endtask

    initial begin
        int          gid;
        logic [31:0] gdata;
        logic        gerr;
        int          order [5] = '{0, 1, 2, 3, 0};

        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        #2;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_alu_en", 64'(alu_en), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        step();
        rst = 1'b0;

        // Single ADD from requester 0.
        req_valid = 4'b0001;
        set_req(0, 32'd5, 32'd7, 4'd0);
        transact(0, gid, gdata, gerr);
        check("d_add_data", 64'(gdata), 64'd12);
        check("d_add_id", 64'(gid), 64'd0);

        // SUB, then signed LT and GT.
        req_valid = 4'b0100;
        set_req(2, 32'd3, 32'd5, 4'd1);
        transact(0, gid, gdata, gerr);
        check("d_sub_data", 64'(gdata), 64'hFFFF_FFFE);
        req_valid = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'd1, 4'd2);
        transact(0, gid, gdata, gerr);
        check("d_lt_data", 64'(gdata), 64'd1);
        req_valid = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'd1, 4'd3);
        transact(0, gid, gdata, gerr);
        check("d_gt_data", 64'(gdata), 64'd0);

        // Backpressure held for five cycles.
        req_valid = 4'b1000;
        set_req(3, 32'hDEAD_0000, 32'h0000_BEEF, 4'd0);
        transact(5, gid, gdata, gerr);
        check("d_stall_data", 64'(gdata), 64'hDEAD_BEEF);

        // Unsupported opcode followed by a normal ADD.
        req_valid = 4'b1000;
        set_req(3, 32'd10, 32'd20, 4'h9);
        transact(0, gid, gdata, gerr);
        check("d_badop_err", 64'(gerr), 64'd1);
        check("d_badop_data", 64'(gdata), 64'd0);
        req_valid = 4'b1000;
        set_req(3, 32'd10, 32'd20, 4'h0);
        transact(0, gid, gdata, gerr);
        check("d_goodop_err", 64'(gerr), 64'd0);

        // Reset while an operation is in EXEC.
        req_valid = 4'b0001;
        set_req(0, 32'd1, 32'd1, 4'd0);
        transact(0, gid, gdata, gerr);
        req_valid = 4'b0010;
        set_req(1, 32'h1234_5678, 32'h1, 4'd0);
        #1;
        check("r_grant1", 64'(req_ready), 64'b0010);
        step();
        check("r_in_exec", 64'(alu_en), 64'd1);
        req_valid = '1;
        rst = 1'b1;
        #1;
        check("r_ready", 64'(req_ready), 64'd0);
        check("r_alu_en", 64'(alu_en), 64'd0);
        check("r_busy", 64'(busy), 64'd0);
        check("r_alu_a", 64'(alu_a), 64'd0);
        check("r_alu_op", 64'(alu_opcode), 64'd0);
        check("r_resp_id", 64'(resp_id), 64'd0);
        step();
        rst = 1'b0;
        m_ptr = 0;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("r_no_resp", 64'(resp_valid), 64'd0);
            step();
        end

        // All requesters valid: strict round-robin, one grant every 3 cycles.
        for (int n = 0; n < 5; n++) begin
            req_valid  = '1;
            resp_ready = 1'b0;
            scramble_ops();
            transact(0, gid, gdata, gerr);
            check("rr_order", 64'(gid), 64'(order[n]));
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++) begin
            req_valid = NUM_REQ'($urandom);
            scramble_ops();
            transact($urandom_range(0, 3), gid, gdata, gerr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_add_arbiter.md
ALU_ADD_ARBITER -- requirements
Module: alu_add_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one alu_add datapath (legal range 2..8).
REQ-002 The block SHALL have parameter ID_W, default $clog2(NUM_REQ), meaning the width of the requester index.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous assertion and release, active-high.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 Port: req_ready  output  NUM_REQ  one-hot acceptance; at most one bit high per cycle.
REQ-007 Port: req_a  input  NUM_REQ*32  packed operand A; requester i uses bits [32i+31:32i].
REQ-008 Port: req_b  input  NUM_REQ*32  packed operand B, same packing.
REQ-009 Port: req_op  input  NUM_REQ*4  packed opcode: 0=ADD, 1=SUB, 2=LT (signed), 3=GT (signed).
REQ-010 Port: alu_a, alu_b  output  32 each  operands to the alu_add instance.
REQ-011 Port: alu_opcode  output  4  opcode to the alu_add instance.
REQ-012 Port: alu_en  output  1  enable to the alu_add instance.
REQ-013 Port: alu_result  input  32  combinational result from the alu_add instance.
REQ-014 Port: resp_valid  output  1  response available.
REQ-015 Port: resp_ready  input  1  consumer accepts response.
REQ-016 Port: resp_id  output  ID_W  index of the requester that owns the response.
REQ-017 Port: resp_data  output  32  registered ALU result.
REQ-018 Port: resp_err  output  1  high when the issued opcode was greater than 3.
REQ-019 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-021 In IDLE with any req_valid bit set, the block SHALL select the first set bit at or above rr_ptr, wrapping modulo NUM_REQ.
REQ-022 In that same cycle it SHALL assert the selected req_ready bit, latch that requester's a/b/op and index, and move to EXEC.
REQ-023 A requester's transfer SHALL occur only in a cycle where both its req_valid and req_ready are high.
REQ-024 In IDLE with no req_valid bit set, the FSM SHALL remain in IDLE and all req_ready bits SHALL be 0.
REQ-025 req_ready SHALL be all-zero in EXEC and RESP, and the block SHALL ignore all req_valid bits in those states.
REQ-026 alu_a, alu_b and alu_opcode SHALL always drive the latched operands.
REQ-027 alu_en SHALL be 1 only in EXEC.
REQ-028 In EXEC the block SHALL register alu_result into resp_data, set resp_err = (latched op > 3), and move to RESP after exactly one cycle.
REQ-029 In RESP, resp_valid SHALL be 1, and resp_id, resp_data and resp_err SHALL stay stable until the cycle with resp_valid && resp_ready.
REQ-030 On the resp_valid && resp_ready cycle, the FSM SHALL return to IDLE and set rr_ptr to (granted index + 1) mod NUM_REQ.
REQ-031 Minimum occupancy SHALL be 3 cycles per operation: accept, then execute, then respond; a new request is accepted in the cycle after the handshake.
REQ-032 resp_valid SHALL be 0 in IDLE and EXEC.
REQ-033 An unsupported opcode SHALL still be issued: resp_data is whatever alu_result returns (0 for the standard ALU) and resp_err = 1.
REQ-034 rr_ptr SHALL change only on a response handshake, so a requester that deasserts valid loses no priority.
REQ-035 Wrap-around: a grant to index NUM_REQ-1 SHALL give index 0 highest priority next.

Reset
REQ-036 Asserting rst SHALL immediately force, asynchronously: state=IDLE, rr_ptr=0, latched operands=0, resp_data=0, resp_id=0, resp_err=0.
REQ-037 During reset all outputs SHALL be 0: req_ready, alu_en, resp_valid, busy and the alu_* buses.
REQ-038 Reset in EXEC or RESP SHALL discard the in-flight operation with no response ever produced.
REQ-039 On the first clock edge after rst deasserts, the block SHALL be able to accept a request.

Verification
REQ-040 Single request 0: ADD, a=5, b=7 -> req_ready[0] in cycle 0; alu_en in cycle 1; resp_valid with resp_data=12 and resp_id=0 in cycle 2.
REQ-041 Requester 2: SUB, a=3, b=5 -> resp_data=0xFFFFFFFE; then requester 1: LT, a=0xFFFFFFFF, b=1 -> resp_data=1; then GT with the same operands -> resp_data=0.
REQ-042 All four req_valid held high with resp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles.
REQ-043 Hold resp_ready=0 for 5 cycles while in RESP -> resp_valid, resp_id and resp_data constant; req_ready stays 0; completion follows on the ready cycle.
REQ-044 Opcode 4'h9 -> resp_err=1 and resp_data=0; the next opcode-0 operation -> resp_err=0.
REQ-045 Assert rst mid-EXEC -> outputs 0 with no clock edge needed, no response is produced, and after release requester 0 has priority.
